// File: rtl/nios_setup_v2_button_ctrl_if.sv
// Avalon-MM slave port bundle for the button controller: 2-bit address,
// read-latency-1 read data and a level IRQ towards the CPU.
interface nios_setup_v2_button_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/nios_setup_v2_button_ctrl.sv
// Push-button controller: sync + per-button debounce FSM, W1C press capture,
// maskable level IRQ and programmable debounce threshold on an Avalon-MM slave.
module nios_setup_v2_button_ctrl #(
  parameter int          WIDTH        = 4,
  parameter int          DEBOUNCE_W   = 20,
  parameter int unsigned DEBOUNCE_RST = 500000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset,
  nios_setup_v2_button_ctrl_if.slave    avs,
  input  logic [WIDTH-1:0]              in_port
);

  typedef enum logic {STABLE, SETTLING} state_e;

  localparam logic [DEBOUNCE_W:0] CNT_ONE = 1;

  logic [WIDTH-1:0]      s1_q, s1_d, s2_q, s2_d;
  logic [WIDTH-1:0]      deb_q, deb_d;
  logic [WIDTH-1:0]      mask_q, mask_d;
  logic [WIDTH-1:0]      edge_q, edge_d;
  logic [DEBOUNCE_W-1:0] thresh_q, thresh_d;
  logic [31:0]           readdata_q, readdata_d;
  state_e                state_q [WIDTH];
  state_e                state_d [WIDTH];
  logic [DEBOUNCE_W-1:0] cnt_q   [WIDTH];
  logic [DEBOUNCE_W-1:0] cnt_d   [WIDTH];

  logic                  wr_en;
  logic [WIDTH-1:0]      press;
  logic [WIDTH-1:0]      clr;
  logic [DEBOUNCE_W:0]   thr_eff;
  logic [DEBOUNCE_W:0]   cnt_run;
  logic                  unused_wdata;

  assign wr_en        = avs.chipselect && !avs.write_n;
  assign unused_wdata = ^avs.writedata;

  // Input synchroniser, normalised so that 1 always means pressed.
  always_comb begin
    s1_d = in_port ^ {WIDTH{ACTIVE_LOW}};
    s2_d = s1_q;
  end

  // cnt_run counts mismatching cycles including the current one, so the
  // first edge that sees s2 != deb already counts as 1; a commit therefore
  // lands T edges after s2 changes, and a lowered THRESH commits next edge.
  always_comb begin
    thr_eff = {1'b0, thresh_q};
    if (thresh_q == '0) thr_eff = CNT_ONE;
    deb_d   = deb_q;
    press   = '0;
    cnt_run = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      cnt_run    = (state_q[i] == STABLE) ? CNT_ONE : ({1'b0, cnt_q[i]} + CNT_ONE);
      if (s2_q[i] == deb_q[i]) begin
        state_d[i] = STABLE;
        cnt_d[i]   = '0;
      end else if (cnt_run >= thr_eff) begin
        deb_d[i]   = s2_q[i];
        press[i]   = s2_q[i];
        state_d[i] = STABLE;
        cnt_d[i]   = '0;
      end else begin
        state_d[i] = SETTLING;
        cnt_d[i]   = cnt_run[DEBOUNCE_W-1:0];
      end
    end
  end

  // Register writes; a press committing on the same edge beats the W1C.
  always_comb begin
    mask_d   = mask_q;
    thresh_d = thresh_q;
    clr      = '0;
    if (wr_en) begin
      unique case (avs.address)
        2'd1:    mask_d   = avs.writedata[WIDTH-1:0];
        2'd2:    clr      = avs.writedata[WIDTH-1:0];
        2'd3:    thresh_d = avs.writedata[DEBOUNCE_W-1:0];
        default: ;
      endcase
    end
    edge_d = (edge_q & ~clr) | press;
  end

  always_comb begin
    readdata_d = '0;
    unique case (avs.address)
      2'd0:    readdata_d = 32'(deb_q);
      2'd1:    readdata_d = 32'(mask_q);
      2'd2:    readdata_d = 32'(edge_q);
      default: readdata_d = 32'(thresh_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q       <= '0;
      s2_q       <= '0;
      deb_q      <= '0;
      mask_q     <= '0;
      edge_q     <= '0;
      thresh_q   <= DEBOUNCE_W'(DEBOUNCE_RST);
      readdata_q <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      deb_q      <= deb_d;
      mask_q     <= mask_d;
      edge_q     <= edge_d;
      thresh_q   <= thresh_d;
      readdata_q <= readdata_d;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign avs.readdata = readdata_q;
  assign avs.irq      = |(edge_q & mask_q);

endmodule
